// File: rtl/elevator_scheduler.sv
// Three-floor elevator request scheduler: synchronizes active-low buttons into
// pending-request lamps and serves them in SCAN order with cycle-count timers.
module elevator_scheduler #(
  parameter int unsigned MOVE_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] btn_n,
  output logic [2:0] req_led,
  output logic [2:0] floor,
  output logic       door,
  output logic       moving,
  output logic       dir_up
);

  localparam logic [CNT_W-1:0] MOVE_LOAD = CNT_W'(MOVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LOAD = CNT_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [2:0]       floor_q, floor_d;
  logic [2:0]       req_q, req_d;
  logic             door_q, door_d;
  logic             moving_q, moving_d;
  logic             dir_q, dir_d;
  logic [2:0]       sync1_q, sync2_q, hist_q;

  logic [2:0] press;
  logic [2:0] req_all;
  logic [2:0] next_floor;
  logic [2:0] ahead;

  // Floors strictly above / below a one-hot position.
  function automatic logic [2:0] above_of(input logic [2:0] f);
    return {f[1] | f[0], f[0], 1'b0};
  endfunction

  function automatic logic [2:0] below_of(input logic [2:0] f);
    return {1'b0, f[2], f[2] | f[1]};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      floor_q  <= 3'b001;
      req_q    <= 3'b000;
      door_q   <= 1'b0;
      moving_q <= 1'b0;
      dir_q    <= 1'b1;
      sync1_q  <= 3'b111;
      sync2_q  <= 3'b111;
      hist_q   <= 3'b111;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      floor_q  <= floor_d;
      req_q    <= req_d;
      door_q   <= door_d;
      moving_q <= moving_d;
      dir_q    <= dir_d;
      sync1_q  <= btn_n;
      sync2_q  <= sync1_q;
      hist_q   <= sync2_q;
    end
  end

  // A press is a falling edge of the synchronized button.
  assign press      = hist_q & ~sync2_q;
  assign req_all    = req_q | press;
  assign next_floor = dir_q ? {floor_q[1:0], 1'b0} : {1'b0, floor_q[2:1]};
  assign ahead      = dir_q ? above_of(next_floor) : below_of(next_floor);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    floor_d  = floor_q;
    req_d    = req_q;
    door_d   = door_q;
    moving_d = moving_q;
    dir_d    = dir_q;
    case (state_q)
      IDLE: begin
        req_d = req_q | (press & ~floor_q);
        if (|(press & floor_q)) begin
          door_d  = 1'b1;
          timer_d = DOOR_LOAD;
          state_d = DOOR_OPEN;
        end else if (|req_q) begin
          // Keep going up if possible, else go down if possible, else up.
          dir_d    = (dir_q & (|(req_q & above_of(floor_q)))) |
                     ~(|(req_q & below_of(floor_q)));
          moving_d = 1'b1;
          timer_d  = MOVE_LOAD;
          state_d  = MOVING;
        end
      end
      MOVING: begin
        req_d = req_all;
        if (timer_q != '0) begin
          timer_d = timer_q - CNT_W'(1);
        end else begin
          floor_d = next_floor;
          if (|(req_all & next_floor)) begin
            req_d    = req_all & ~next_floor;
            moving_d = 1'b0;
            door_d   = 1'b1;
            timer_d  = DOOR_LOAD;
            state_d  = DOOR_OPEN;
          end else if (|(req_all & ahead)) begin
            timer_d = MOVE_LOAD;
          end else begin
            moving_d = 1'b0;
            state_d  = IDLE;
          end
        end
      end
      DOOR_OPEN: begin
        req_d = req_q | (press & ~floor_q);
        if (|(press & floor_q)) begin
          timer_d = DOOR_LOAD;
        end else if (timer_q != '0) begin
          timer_d = timer_q - CNT_W'(1);
        end else begin
          door_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_led = req_q;
  assign floor   = floor_q;
  assign door    = door_q;
  assign moving  = moving_q;
  assign dir_up  = dir_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler: a vector table for a basic trip plus
// hand-written sequences for door extension, intermediate stop, SCAN and reset.
module tb_elevator_scheduler;

  logic       clk;
  logic       rst_n;
  logic [2:0] btn_n;
  logic [2:0] req_led;
  logic [2:0] floor;
  logic       door;
  logic       moving;
  logic       dir_up;

  int errors = 0;
  int checks = 0;

  elevator_scheduler #(.MOVE_CYCLES(8), .DOOR_CYCLES(4), .CNT_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_n  (btn_n),
    .req_led(req_led),
    .floor  (floor),
    .door   (door),
    .moving (moving),
    .dir_up (dir_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors + 1);
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [2:0] btn;
    int         hold;
    int         wt;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[13];

  // Packed view: {req_led, floor, door, moving, dir_up}.
  function automatic logic [8:0] pk(input logic [2:0] r, input logic [2:0] f,
                                    input logic d, input logic m, input logic u);
    return {r, f, d, m, u};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [8:0] exp);
    logic [8:0] got;
    got = {req_led, floor, door, moving, dir_up};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got req=%b floor=%b door=%b moving=%b dir=%b, want req=%b floor=%b door=%b moving=%b dir=%b",
               name, got[8:6], got[5:3], got[2], got[1], got[0],
               exp[8:6], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic press(input logic [2:0] b, input int hold);
    btn_n = b;
    step(hold);
    btn_n = 3'b111;
  endtask

  initial begin
    // Trip 1 -> 3, then a current-floor press at floor 3.
    vecs[0]  = '{"trip_req_rise",   3'b011, 2, 1, pk(3'b100, 3'b001, 0, 0, 1)};
    vecs[1]  = '{"trip_move_start", 3'b111, 0, 1, pk(3'b100, 3'b001, 0, 1, 1)};
    vecs[2]  = '{"trip_step1_end",  3'b111, 0, 7, pk(3'b100, 3'b001, 0, 1, 1)};
    vecs[3]  = '{"trip_floor2",     3'b111, 0, 1, pk(3'b100, 3'b010, 0, 1, 1)};
    vecs[4]  = '{"trip_step2_end",  3'b111, 0, 7, pk(3'b100, 3'b010, 0, 1, 1)};
    vecs[5]  = '{"trip_arrive3",    3'b111, 0, 1, pk(3'b000, 3'b100, 1, 0, 1)};
    vecs[6]  = '{"trip_door_last",  3'b111, 0, 3, pk(3'b000, 3'b100, 1, 0, 1)};
    vecs[7]  = '{"trip_door_close", 3'b111, 0, 1, pk(3'b000, 3'b100, 0, 0, 1)};
    vecs[8]  = '{"trip_idle_hold",  3'b111, 0, 10, pk(3'b000, 3'b100, 0, 0, 1)};
    vecs[9]  = '{"cur_press_sync",  3'b011, 2, 0, pk(3'b000, 3'b100, 0, 0, 1)};
    vecs[10] = '{"cur_press_door",  3'b111, 0, 1, pk(3'b000, 3'b100, 1, 0, 1)};
    vecs[11] = '{"cur_press_dwell", 3'b111, 0, 3, pk(3'b000, 3'b100, 1, 0, 1)};
    vecs[12] = '{"cur_press_close", 3'b111, 0, 1, pk(3'b000, 3'b100, 0, 0, 1)};

    // Reset with buttons pulsed.
    rst_n = 1'b0;
    btn_n = 3'b000;
    step(1);
    btn_n = 3'b111;
    step(1);
    chk("reset_values", pk(3'b000, 3'b001, 0, 0, 1));
    rst_n = 1'b1;
    step(5);
    chk("reset_release_stable", pk(3'b000, 3'b001, 0, 0, 1));

    for (int i = 0; i < 13; i++) begin
      press(vecs[i].btn, vecs[i].hold);
      step(vecs[i].wt);
      chk(vecs[i].name, vecs[i].exp);
    end

    // Door extension by a second current-floor press at floor 3.
    press(3'b011, 1);
    step(2);
    chk("ext_door_open", pk(3'b000, 3'b100, 1, 0, 1));
    step(1);
    press(3'b011, 1);
    step(1);
    chk("ext_door_mid", pk(3'b000, 3'b100, 1, 0, 1));
    step(1);
    chk("ext_door_extended", pk(3'b000, 3'b100, 1, 0, 1));
    step(3);
    chk("ext_door_last", pk(3'b000, 3'b100, 1, 0, 1));
    step(1);
    chk("ext_door_close", pk(3'b000, 3'b100, 0, 0, 1));

    // Intermediate stop: request 3 from floor 1, press 2 on step cycle 3.
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    press(3'b011, 2);
    step(4);
    press(3'b101, 2);
    step(1);
    chk("mid_both_pending", pk(3'b110, 3'b001, 0, 1, 1));
    step(3);
    chk("mid_stop_floor2", pk(3'b100, 3'b010, 1, 0, 1));
    step(4);
    chk("mid_door_closed", pk(3'b100, 3'b010, 0, 0, 1));
    step(1);
    chk("mid_resume", pk(3'b100, 3'b010, 0, 1, 1));
    step(8);
    chk("mid_arrive3", pk(3'b000, 3'b100, 1, 0, 1));
    step(4);
    chk("mid_final_idle", pk(3'b000, 3'b100, 0, 0, 1));

    // SCAN: go to floor 2, then request 1 and 3 together.
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    press(3'b101, 2);
    step(14);
    chk("scan_at_floor2", pk(3'b000, 3'b010, 0, 0, 1));
    press(3'b010, 2);
    step(1);
    chk("scan_both_latched", pk(3'b101, 3'b010, 0, 0, 1));
    step(1);
    chk("scan_go_up", pk(3'b101, 3'b010, 0, 1, 1));
    step(8);
    chk("scan_arrive3", pk(3'b001, 3'b100, 1, 0, 1));
    step(4);
    chk("scan_door3_closed", pk(3'b001, 3'b100, 0, 0, 1));
    step(1);
    chk("scan_reverse", pk(3'b001, 3'b100, 0, 1, 0));
    step(8);
    chk("scan_pass_floor2", pk(3'b001, 3'b010, 0, 1, 0));
    step(8);
    chk("scan_arrive1", pk(3'b000, 3'b001, 1, 0, 0));

    // Reset during MOVING cycle 5 toward floor 3.
    step(4);
    chk("rm_idle_floor1", pk(3'b000, 3'b001, 0, 0, 0));
    press(3'b011, 2);
    step(6);
    chk("rm_moving", pk(3'b100, 3'b001, 0, 1, 1));
    rst_n = 1'b0;
    step(1);
    chk("rm_reset", pk(3'b000, 3'b001, 0, 0, 1));
    rst_n = 1'b1;
    step(5);
    chk("rm_after_release", pk(3'b000, 3'b001, 0, 0, 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Request scheduler and motion sequencer for the three-floor elevator. It captures active-low hall/car button presses into pending-request lamps and serves them in SCAN order, always continuing in the current direction while requests remain ahead. It generates the one-hot floor position, door and moving indications that drive the floor, LED and door outputs of the top level. Movement and door dwell are cycle-count timers, so the block needs no position sensors.

## Interface

- MOVE_CYCLES, 8, clk cycles to travel one floor (≥1)
- DOOR_CYCLES, 4, clk cycles the door stays open (≥1)
- CNT_W, 8, timer width; MOVE_CYCLES and DOOR_CYCLES must be < 2^CNT_W
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- btn_n  in  3  buttons, bit i = floor i+1, active-low, idle high, asynchronous
- req_led  out  3  pending request per floor
- floor  out  3  one-hot current floor, bit0 = floor 1
- door  out  1  door open
- moving  out  1  car travelling
- dir_up  out  1  current scan direction (1 = up)

## Operation

- Reset values, applied on any clk edge with rst_n=0: req_led=000, floor=001, door=0, moving=0, dir_up=1, state IDLE, timer=0, synchronizer flops=111. Reset mid-operation abandons the trip; the car is taken to be at floor 1.
- Input capture: each btn_n bit passes through a 2-flop synchronizer plus a history flop. A press is a 1→0 transition of the synchronized value. Holding a button produces one press.
- Press handling:
  - Press for the current floor in IDLE or DOOR_OPEN: not latched. Door opens, or the door timer restarts, with a DOOR_CYCLES dwell.
  - Any other press: sets req_led[i]. Pressing an already-pending floor has no effect.
- States:
  - IDLE: door=0, moving=0. If req_led≠0, apply the direction rule:
    - dir_up=1 and a request exists above: go up.
    - Otherwise, a request exists below: dir_up←0, go down.
    - Otherwise: dir_up←1, go up.
    - On a move: enter MOVING, moving←1, timer←MOVE_CYCLES-1.
  - MOVING: timer decrements each cycle. At timer=0, floor shifts one position in dir_up direction, then:
    - Request at the new floor: clear it, moving←0, door←1, timer←DOOR_CYCLES-1, enter DOOR_OPEN.
    - Else a request further in dir_up: stay in MOVING, timer reloads.
    - Else: moving←0, enter IDLE.
  - DOOR_OPEN: timer decrements. At timer=0, door←0 and enter IDLE.
- floor never leaves 001..100. A move past floor 3 or below floor 1 is never issued.
- A press for floor i in the same cycle the car arrives at i: treated as served. req_led[i] ends 0 and the door opens.
- Presses during MOVING for any floor, including the one just departed, are latched normally.

## Timing

- Press latency: if btn_n[i] is low at edge k (first sampling), req_led[i] rises at edge k+2. A low pulse shorter than one clk period may be lost.
- IDLE→MOVING: moving rises on the edge after req_led shows a request (1 cycle of decision latency). IDLE with nothing pending holds indefinitely.
- Each floor step takes exactly MOVE_CYCLES cycles of moving=1. floor changes on the same edge the MOVING-state decision is taken.
- door is high for exactly DOOR_CYCLES cycles, extended by DOOR_CYCLES from any current-floor press. Door-open and moving are mutually exclusive on every cycle.
- The minimum gap between door falling and moving rising is 1 cycle (IDLE).

## Test plan

- Reset: hold rst_n=0 for 2 edges with buttons pulsed → floor=001, req_led=000, door=0, moving=0, dir_up=1. Release; outputs stay stable with no presses.
- Single trip: at floor 1 pulse btn_n=011 for 2 cycles.
  - req_led=100 at k+2; moving=1 next edge.
  - floor=010 after 8 cycles, floor=100 after 16.
  - Then req_led=000, door=1 for 4 cycles, then IDLE.
- Current-floor press: at floor 1 in IDLE pulse btn_n=110 → req_led stays 000, door=1 for 4 cycles, moving stays 0. A second press during the dwell extends door to 4 cycles after that press.
- Intermediate stop: request floor 3; at cycle 3 of the first step press floor 2.
  - Car stops at floor=010, door=1 for 4 cycles, req_led=100 remains.
  - Then moves to floor=100 and serves it.
- SCAN order: at floor 2 with dir_up=1, latch floors 1 and 3 in the same cycle → goes up to floor 3 first. After its door closes: dir_up=0, travels 16 cycles to floor 1, req_led=000.
- Reset mid-move: assert rst_n=0 at MOVING cycle 5 with req_led=100 → next edge floor=001, moving=0, req_led=000, dir_up=1.
